rect_wave_gen: RTL and testbench
================================

# rect_wave_gen

Cycle-accurate digital trapezoid/rectangle waveform generator that produces the amplitude code driving the rectangular and pulse current/voltage sources (Irect, Ipulse, Vac-style stimulus DAC path) in mixed-signal test setups. It sits directly upstream of the source/DAC stage. It turns delay, ramp, high-time and low-time settings, given in clock cycles, into a per-cycle level word. The generator is periodic like Irect; single-shot Ipulse-style operation is a compile option.

## Interface
- `W`, 12: level/amplitude word width.
- `CW`, 16: timing counter width.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin waveform; sampled only in IDLE.
- `stop` in 1: abort from any state.
- `iv` in W: initial/low level code.
- `pv` in W: pulse/high level code; must satisfy pv >= iv.
- `rstep` in W: per-cycle rise increment; 0 = instantaneous.
- `fstep` in W: per-cycle fall decrement; 0 = instantaneous.
- `td` in CW: delay cycles before first rise.
- `th` in CW: high-plateau cycles.
- `tl` in CW: low-plateau cycles.
- `level` out W: waveform code to source stage.
- `phase` out 3: state code; IDLE=0, DELAY=1, RISE=2, HIGH=3, FALL=4, LOW=5.
- `busy` out 1: state != IDLE.
- `period_tick` out 1: one-cycle pulse on each LOW->RISE transition.

## Operation
- Settings (iv, pv, rstep, fstep, td, th, tl) are latched on the accepted start; later changes have no effect until the next start.
- FSM:
  - IDLE: start -> DELAY, or RISE if td=0. Level is driven to latched iv on entry.
  - DELAY: occupies td cycles -> RISE.
  - RISE: each cycle level <= min(level+rstep, pv), computed in W+1 bits with no wrap. rstep=0 sets level to pv in one cycle. Transition to HIGH occurs in the same edge that level reaches pv.
  - HIGH: occupies max(th,1) cycles, counted from entry -> FALL.
  - FALL: each cycle level <= max(level-fstep, iv), computed in W+1 bits, floor at iv. fstep=0 sets level to iv in one cycle. Transition to LOW occurs on the edge that level reaches iv.
  - LOW: occupies max(tl,1) cycles -> RISE, with period_tick asserted for the following cycle.
- stop: next edge goes to IDLE with level=iv latched. stop beats start when both are asserted in the same cycle.
- start while busy is ignored.
- pv < iv: pv is treated as iv. RISE lasts one cycle and FALL lasts one cycle with a flat level.
- Counters are CW bits and never wrap; a plateau of 2^CW-1 is the maximum.

## Timing
- Reset (async, rst_n=0): state IDLE, level=0, phase=0, busy=0, period_tick=0, latched settings=0.
- All outputs are registered. Latency from the start edge to the first level change is td+2 edges (rstep>0).
- Release of rst_n is synchronised internally. The first active edge is the second clk edge after deassertion.
- Reset asserted mid-waveform forces the reset values immediately, with no glitch to intermediate values.

## Configuration
- `RECT_WAVE_GEN_ONESHOT_EN` defined:
  - Adds an input `oneshot` (1 bit), latched with the other settings on start.
  - When latched oneshot=1, FALL -> IDLE instead of LOW, so no period_tick is produced. This gives Ipulse semantics.
  - When latched oneshot=0, behaviour is periodic.
- Undefined: the port is absent and the generator is always periodic.

## Test plan
- Periodic waveform:
  - Stimulus: iv=0, pv=100, rstep=25, fstep=50, td=2, th=3, tl=2; start pulsed before edge 1.
  - Required level after edges 1..14: 0,0,0,25,50,75,100,100,100,100,50,0,0,0.
  - period_tick high after edge 14. Pattern repeats from RISE.
- Instantaneous ramps:
  - Stimulus: rstep=0, fstep=0, iv=10, pv=4000, td=0, th=1, tl=1.
  - Required: level toggles 10/4000 with one-cycle RISE/FALL steps; level never exceeds 4000 or drops below 10.
- Saturation:
  - Stimulus: iv=0, pv=4095 (W=12), rstep=3000.
  - Required: level goes 3000 then 4095 with no wrap; fstep=3000 gives 1095 then 0.
- Stop and start interaction:
  - stop asserted during HIGH -> IDLE next edge, level=iv, busy=0.
  - start and stop in the same cycle while IDLE -> stays IDLE.
  - start during RISE -> ignored, waveform unchanged.
- Async reset mid-FALL:
  - Stimulus: rst_n driven low between edges.
  - Required: level=0, phase=0, busy=0 immediately; after release, outputs stay idle until start.
- With `RECT_WAVE_GEN_ONESHOT_EN`, oneshot=1:
  - Required: a single trapezoid, then IDLE with level=iv and period_tick never asserted.
  - Required: changing oneshot mid-waveform has no effect.

Source files
------------

// File: rtl/rect_wave_gen.sv
// Periodic trapezoid/rectangle level generator driving the source/DAC stage.
// Optional single-shot (Ipulse) mode: define RECT_WAVE_GEN_ONESHOT_EN.
module rect_wave_gen #(
    parameter int W  = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
`ifdef RECT_WAVE_GEN_ONESHOT_EN
    input  logic          oneshot,
`endif
    input  logic [W-1:0]  iv,
    input  logic [W-1:0]  pv,
    input  logic [W-1:0]  rstep,
    input  logic [W-1:0]  fstep,
    input  logic [CW-1:0] td,
    input  logic [CW-1:0] th,
    input  logic [CW-1:0] tl,
    output logic [W-1:0]  level,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          period_tick
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        RISE  = 3'd2,
        HIGH  = 3'd3,
        FALL  = 3'd4,
        LOW   = 3'd5
    } state_t;

    state_t        state;
    logic          run;
    logic [CW-1:0] cnt;
    logic [W-1:0]  iv_q, pv_q, rstep_q, fstep_q;
    logic [CW-1:0] td_q, th_q, tl_q;
    logic          oneshot_q;
    logic [W:0]    rise_sum, fall_diff;
    logic [W-1:0]  rise_next, fall_next;

    // Ramps are evaluated one bit wider so a large step saturates instead of wrapping.
    always_comb begin
        rise_sum  = {1'b0, level} + {1'b0, rstep_q};
        fall_diff = {1'b0, level} - {1'b0, fstep_q};
        rise_next = pv_q;
        if (rstep_q != '0 && rise_sum < {1'b0, pv_q})
            rise_next = rise_sum[W-1:0];
        fall_next = iv_q;
        if (fstep_q != '0 && !fall_diff[W] && fall_diff[W-1:0] > iv_q)
            fall_next = fall_diff[W-1:0];
    end

    assign phase = state;

`ifndef RECT_WAVE_GEN_ONESHOT_EN
    assign oneshot_q = 1'b0;
`endif

    // Reset asserts at once; release is taken through run so the FSM
    // first acts on the second clock edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: latched settings are reset too, so a stop issued before
            // any start drives a defined level of zero.
            run         <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            level       <= '0;
            busy        <= 1'b0;
            period_tick <= 1'b0;
            iv_q        <= '0;
            pv_q        <= '0;
            rstep_q     <= '0;
            fstep_q     <= '0;
            td_q        <= '0;
            th_q        <= '0;
            tl_q        <= '0;
`ifdef RECT_WAVE_GEN_ONESHOT_EN
            oneshot_q   <= 1'b0;
`endif
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            period_tick <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                level <= iv_q;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: if (start) begin
                        iv_q    <= iv;
                        pv_q    <= (pv < iv) ? iv : pv;
                        rstep_q <= rstep;
                        fstep_q <= fstep;
                        td_q    <= td;
                        th_q    <= th;
                        tl_q    <= tl;
`ifdef RECT_WAVE_GEN_ONESHOT_EN
                        oneshot_q <= oneshot;
`endif
                        level   <= iv;
                        cnt     <= CW'(1);
                        busy    <= 1'b1;
                        state   <= (td == '0) ? RISE : DELAY;
                    end
                    DELAY: begin
                        if (cnt >= td_q) state <= RISE;
                        else             cnt   <= cnt + CW'(1);
                    end
                    RISE: begin
                        level <= rise_next;
                        if (rise_next == pv_q) begin
                            state <= HIGH;
                            cnt   <= CW'(1);
                        end
                    end
                    HIGH: begin
                        if (cnt >= th_q) state <= FALL;
                        else             cnt   <= cnt + CW'(1);
                    end
                    FALL: begin
                        level <= fall_next;
                        if (fall_next == iv_q) begin
                            if (oneshot_q) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= LOW;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    LOW: begin
                        if (cnt >= tl_q) begin
                            state       <= RISE;
                            period_tick <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rect_wave_gen.sv
// Self-checking bench for rect_wave_gen: directed vectors plus randomized
// configurations compared against a trace model built from the waveform rules.
module tb_rect_wave_gen;

    localparam int W  = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [W-1:0]  iv = '0, pv = '0, rstep = '0, fstep = '0;
    logic [CW-1:0] td = '0, th = '0, tl = '0;
`ifdef RECT_WAVE_GEN_ONESHOT_EN
    logic          oneshot = 1'b0;
`endif
    logic [W-1:0]  level;
    logic [2:0]    phase;
    logic          busy;
    logic          period_tick;

    rect_wave_gen #(.W(W), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
`ifdef RECT_WAVE_GEN_ONESHOT_EN
        .oneshot     (oneshot),
`endif
        .iv          (iv),
        .pv          (pv),
        .rstep       (rstep),
        .fstep       (fstep),
        .td          (td),
        .th          (th),
        .tl          (tl),
        .level       (level),
        .phase       (phase),
        .busy        (busy),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int iv, pv, rstep, fstep, td, th, tl;
        bit os;
    } cfg_t;

    typedef struct {
        logic [W-1:0] lv;
        logic [2:0]   ph;
        logic         tk;
    } samp_t;

    samp_t exp_q[$];

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input int lv, input int ph, input int tk);
        samp_t s;
        s.lv = W'(lv);
        s.ph = 3'(ph);
        s.tk = tk[0];
        exp_q.push_back(s);
    endfunction

    // Expected outputs after each edge, starting with the start edge, derived
    // from plateau lengths and saturating ramps.
    task automatic build_trace(input cfg_t c, input int n);
        int lv, pe;
        exp_q.delete();
        pe = (c.pv < c.iv) ? c.iv : c.pv;
        lv = c.iv;
        push(lv, (c.td == 0) ? 2 : 1, 0);
        for (int k = 1; k < c.td; k++) push(lv, 1, 0);
        if (c.td > 0) push(lv, 2, 0);
        while (exp_q.size() < n) begin
            do begin
                lv = (c.rstep == 0 || lv + c.rstep > pe) ? pe : lv + c.rstep;
                push(lv, (lv == pe) ? 3 : 2, 0);
            end while (lv != pe);
            for (int k = 1; k < ((c.th < 1) ? 1 : c.th); k++) push(pe, 3, 0);
            push(pe, 4, 0);
            do begin
                lv = (c.fstep == 0 || lv - c.fstep < c.iv) ? c.iv : lv - c.fstep;
                push(lv, (lv != c.iv) ? 4 : (c.os ? 0 : 5), 0);
            end while (lv != c.iv);
            if (c.os) begin
                while (exp_q.size() < n) push(c.iv, 0, 0);
            end else begin
                for (int k = 1; k < ((c.tl < 1) ? 1 : c.tl); k++) push(c.iv, 5, 0);
                push(c.iv, 2, 1);
            end
        end
    endtask

    task automatic apply_cfg(input cfg_t c);
        iv    = W'(c.iv);
        pv    = W'(c.pv);
        rstep = W'(c.rstep);
        fstep = W'(c.fstep);
        td    = CW'(c.td);
        th    = CW'(c.th);
        tl    = CW'(c.tl);
`ifdef RECT_WAVE_GEN_ONESHOT_EN
        oneshot = c.os;
`endif
    endtask

    task automatic scramble_inputs();
        iv    = W'($urandom);
        pv    = W'($urandom);
        rstep = W'($urandom);
        fstep = W'($urandom);
        td    = CW'($urandom_range(0, 9));
        th    = CW'($urandom_range(0, 9));
        tl    = CW'($urandom_range(0, 9));
`ifdef RECT_WAVE_GEN_ONESHOT_EN
        oneshot = 1'($urandom);
`endif
    endtask

    task automatic go_idle();
        start = 1'b0;
        stop  = 1'b1;
        edge_step();
        stop  = 1'b0;
    endtask

    // Starts the waveform and compares every edge against the model trace.
    task automatic run_trace(input cfg_t c, input int n, input bit scramble,
                             input bit pulse_in_rise, input string name);
        bit pulsed = 1'b0;
        build_trace(c, n);
        apply_cfg(c);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                start = 1'b0;
                if (scramble) scramble_inputs();
                if (pulse_in_rise && !pulsed && exp_q[i-1].ph == 3'd2) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end
            end
            edge_step();
            n_tests++;
            if (level !== exp_q[i].lv || phase !== exp_q[i].ph ||
                busy !== (exp_q[i].ph != 3'd0) || period_tick !== exp_q[i].tk) begin
                n_fail++;
                $display("FAIL %s edge %0d: got level=%0d phase=%0d busy=%0b tick=%0b, want level=%0d phase=%0d busy=%0b tick=%0b",
                         name, i + 1, level, phase, busy, period_tick,
                         exp_q[i].lv, exp_q[i].ph, exp_q[i].ph != 3'd0, exp_q[i].tk);
            end
        end
        start = 1'b0;
        if (pulse_in_rise && !pulsed) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no RISE cycle reached for the start pulse", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if (level !== '0 || phase !== 3'd0 || busy !== 1'b0 || period_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got level=%0d phase=%0d busy=%0b tick=%0b, want all 0",
                     level, phase, busy, period_tick);
        end
        rst_n = 1'b1;
        repeat (3) edge_step();
    endtask

    task automatic test_periodic();
        int want[14] = '{0, 0, 0, 25, 50, 75, 100, 100, 100, 100, 50, 0, 0, 0};
        cfg_t c = '{iv: 0, pv: 100, rstep: 25, fstep: 50, td: 2, th: 3, tl: 2, os: 0};
        apply_cfg(c);
        start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            edge_step();
            start = 1'b0;
            n_tests++;
            if (level !== W'(want[i]) || period_tick !== (i == 13)) begin
                n_fail++;
                $display("FAIL periodic_vector edge %0d: got level=%0d tick=%0b, want level=%0d tick=%0b",
                         i + 1, level, period_tick, want[i], i == 13);
            end
        end
        go_idle();
        run_trace(c, 45, 1'b1, 1'b0, "periodic_model");
        go_idle();
    endtask

    task automatic test_instant();
        cfg_t c = '{iv: 10, pv: 4000, rstep: 0, fstep: 0, td: 0, th: 1, tl: 1, os: 0};
        apply_cfg(c);
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            edge_step();
            start = 1'b0;
            n_tests++;
            if (level !== W'(10) && level !== W'(4000)) begin
                n_fail++;
                $display("FAIL instant_bounds edge %0d: got level=%0d, want 10 or 4000", i + 1, level);
            end
        end
        go_idle();
        run_trace(c, 24, 1'b0, 1'b0, "instant_model");
        go_idle();
    endtask

    task automatic test_saturation();
        int want[7] = '{0, 3000, 4095, 4095, 1095, 0, 0};
        cfg_t c = '{iv: 0, pv: 4095, rstep: 3000, fstep: 3000, td: 0, th: 1, tl: 1, os: 0};
        apply_cfg(c);
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            edge_step();
            start = 1'b0;
            n_tests++;
            if (level !== W'(want[i])) begin
                n_fail++;
                $display("FAIL saturation edge %0d: got level=%0d, want %0d", i + 1, level, want[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        cfg_t c;
        for (int r = 0; r < 10; r++) begin
            c.iv    = int'($urandom_range(0, 4095));
            c.pv    = (r % 3 == 2) ? int'($urandom_range(0, 4095))
                                   : int'($urandom_range(c.iv, 4095));
            c.rstep = int'($urandom_range(0, 1500));
            c.fstep = int'($urandom_range(0, 1500));
            c.td    = int'($urandom_range(0, 4));
            c.th    = int'($urandom_range(0, 4));
            c.tl    = int'($urandom_range(0, 4));
            c.os    = 1'b0;
            run_trace(c, 60, 1'b1, 1'b0, "random_cfg");
            go_idle();
        end
    endtask

    task automatic test_stop_start();
        bit found = 1'b0;
        cfg_t c = '{iv: 7, pv: 100, rstep: 25, fstep: 50, td: 1, th: 5, tl: 2, os: 0};
        apply_cfg(c);
        start = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            edge_step();
            start = 1'b0;
            if (phase == 3'd3) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL stop_reach_high: got phase=%0d after 20 edges, want 3", phase);
        end
        stop = 1'b1;
        edge_step();
        stop = 1'b0;
        n_tests++;
        if (phase !== 3'd0 || level !== W'(7) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_in_high: got phase=%0d level=%0d busy=%0b, want 0/7/0", phase, level, busy);
        end
        iv    = W'(55);
        start = 1'b1;
        stop  = 1'b1;
        edge_step();
        start = 1'b0;
        stop  = 1'b0;
        n_tests++;
        if (phase !== 3'd0 || level !== W'(7) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_idle: got phase=%0d level=%0d busy=%0b, want 0/7/0", phase, level, busy);
        end
        edge_step();
        n_tests++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_idle_hold: got phase=%0d busy=%0b, want 0/0", phase, busy);
        end
        c = '{iv: 20, pv: 900, rstep: 100, fstep: 300, td: 1, th: 2, tl: 1, os: 0};
        run_trace(c, 40, 1'b1, 1'b1, "start_in_rise");
        go_idle();
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        cfg_t c = '{iv: 0, pv: 100, rstep: 25, fstep: 50, td: 2, th: 3, tl: 2, os: 0};
        apply_cfg(c);
        start = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            edge_step();
            start = 1'b0;
            if (phase == 3'd4) found = 1'b1;
        end
        n_tests++;
        if (!found || level === '0) begin
            n_fail++;
            $display("FAIL reach_fall: got phase=%0d level=%0d, want phase 4 with nonzero level", phase, level);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (level !== '0 || phase !== 3'd0 || busy !== 1'b0 || period_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got level=%0d phase=%0d busy=%0b tick=%0b, want all 0",
                     level, phase, busy, period_tick);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            n_tests++;
            if (level !== '0 || phase !== 3'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle edge %0d: got level=%0d phase=%0d busy=%0b, want 0/0/0",
                         i + 1, level, phase, busy);
            end
        end
    endtask

    task automatic test_reset_release();
        cfg_t c = '{iv: 0, pv: 100, rstep: 25, fstep: 50, td: 2, th: 3, tl: 2, os: 0};
        rst_n = 1'b0;
        apply_cfg(c);
        start = 1'b1;
        #4 rst_n = 1'b1;
        edge_step();
        n_tests++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release_edge1: got phase=%0d busy=%0b, want 0/0", phase, busy);
        end
        edge_step();
        start = 1'b0;
        n_tests++;
        if (phase !== 3'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL release_edge2: got phase=%0d busy=%0b, want 1/1", phase, busy);
        end
        go_idle();
    endtask

`ifdef RECT_WAVE_GEN_ONESHOT_EN
    task automatic test_oneshot();
        cfg_t c = '{iv: 30, pv: 500, rstep: 120, fstep: 200, td: 1, th: 2, tl: 2, os: 1};
        run_trace(c, 30, 1'b1, 1'b0, "oneshot_single");
        go_idle();
        c.os = 1'b0;
        run_trace(c, 40, 1'b1, 1'b0, "oneshot_off_periodic");
        go_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_instant();
        test_saturation();
        test_random();
        test_stop_start();
        test_async_reset();
        test_reset_release();
`ifdef RECT_WAVE_GEN_ONESHOT_EN
        test_oneshot();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
